mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of ACCESS cycles without mem_ack before an access is aborted (range 1..255).
REQ-002 Parameter: ERR_DATA, default 32'hDEADBEEF, read data returned on an aborted access.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU (multicycle control/datapath) access request, held until cpu_ready.
REQ-006 cpu_we, cpu_addr, cpu_wdata  input  1/32/32  CPU write enable, byte address, write data; stable while cpu_req is high.
REQ-007 cpu_rdata, cpu_ready, cpu_err  output  32/1/1  CPU read data, one-cycle completion pulse, abort flag.
REQ-008 dma_req, dma_we, dma_addr, dma_wdata  input  1/1/32/32  DMA/debug port request, same rules as CPU.
REQ-009 dma_rdata, dma_ready, dma_err  output  32/1/1  DMA response, same rules as CPU.
REQ-010 mem_en, mem_we, mem_addr, mem_wdata  output  1/1/32/32  single-port unified memory command.
REQ-011 mem_rdata, mem_ack  input  32/1  memory read data, valid in the cycle mem_ack is high.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-014 IDLE: if any req is high, SHALL grant one requester, latch its we/addr/wdata, and go to ACCESS; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: with one request, grant it; with both, grant the requester not granted last.
REQ-016 ACCESS: mem_en SHALL be high and mem_we/addr/wdata SHALL be driven from the latched values every cycle.
REQ-017 ACCESS: on mem_ack, SHALL latch mem_rdata (reads only) and go to DONE.
REQ-018 DONE: SHALL pulse ready of the granted port for exactly one cycle with rdata valid, update last-grant, and return to IDLE.
REQ-019 rdata of each port SHALL hold its last value until that port's next completion; write completions SHALL leave rdata unchanged.
REQ-020 With zero-wait memory (mem_ack in the first ACCESS cycle), ready SHALL be high in the third cycle after req is sampled; each wait cycle adds one.
REQ-021 A req still high in the cycle after ready SHALL be treated as a new request.
REQ-022 mem_ack outside ACCESS SHALL be ignored.
REQ-023 The non-granted port's ready/err SHALL stay low, and its request SHALL remain pending.

Reset
REQ-024 Reset SHALL force IDLE, mem_en=0, mem_we=0, all ready/err=0, rdata=0, busy=0, and last-grant=DMA so the CPU wins the first tie.
REQ-025 Reset during ACCESS SHALL abort silently: no ready pulse, and mem_en low from the next cycle.

Configuration
REQ-026 With macro MEM_ARBITER_TIMEOUT_EN defined, an 8-bit counter SHALL run in ACCESS; after TIMEOUT cycles without mem_ack, the FSM SHALL go to DONE with rdata=ERR_DATA (reads) and assert err together with ready.
REQ-027 Without MEM_ARBITER_TIMEOUT_EN, ACCESS SHALL wait indefinitely, cpu_err/dma_err SHALL be constant 0, and no counter SHALL be built.
REQ-028 mem_ack in the same cycle the timeout expires SHALL win: normal completion, err=0.

Structure
REQ-029 Package mem_arbiter_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), the grant enum (GNT_CPU/GNT_DMA) and the ERR_DATA default constant.
REQ-030 The two-way round-robin choice SHALL be a sub-module rr_arb2 (inputs req[1:0], last grant; output grant).

Verification
REQ-031 CPU read addr 0x40, mem_ack in first ACCESS cycle, mem_rdata=0x12345678 -> cpu_ready on 3rd cycle, cpu_rdata=0x12345678, dma_ready=0.
REQ-032 cpu_req and dma_req rise together after reset -> CPU served first, then DMA; both held high again -> DMA then CPU, alternating.
REQ-033 DMA write addr 0x100, data 0xCAFEF00D, 4 wait cycles -> mem_en high 5 cycles with mem_we=1, mem_addr=0x100, mem_wdata=0xCAFEF00D; dma_ready 1 cycle; dma_rdata unchanged.
REQ-034 Macro defined, TIMEOUT=4, CPU read with mem_ack never asserted -> after 4 ACCESS cycles cpu_ready=1, cpu_err=1, cpu_rdata=0xDEADBEEF; macro undefined -> busy stays high.
REQ-035 Reset asserted in the 2nd ACCESS cycle -> next cycle mem_en=0, busy=0, no ready pulse; cpu_req and dma_req both high after reset -> CPU granted.
REQ-036 mem_ack pulsed while IDLE with no requests -> no state change, all ready outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_arbiter_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Requester identity, used both for the current grant and the last grant.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_e;

    // Read data returned when an access is aborted by the timeout.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin chooser: a lone request wins outright, a tie goes to
// the requester that was not served last. req[0] is the CPU, req[1] the DMA.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  grant_e     last_gnt,
    output grant_e     grant
);

    // Pick the winner from the request pair and the previous grant.
    always_comb begin
        grant = GNT_CPU;
        case (req)
            2'b01:   grant = GNT_CPU;
            2'b10:   grant = GNT_DMA;
            2'b11:   grant = (last_gnt == GNT_DMA) ? GNT_CPU : GNT_DMA;
            default: grant = GNT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a DMA/debug port onto one single-port memory.
// Each access runs IDLE -> ACCESS -> DONE; ready pulses for one cycle in DONE.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort accesses that see
// no mem_ack within TIMEOUT ACCESS cycles (returns ERR_DATA and raises err).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ready,
    output logic        dma_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    state_e      state_r;
    state_e      state_s;
    grant_e      gnt_r;
    grant_e      last_gnt_r;
    grant_e      arb_gnt_s;
    logic        tmo_s;
    logic        finish_s;
    logic        mem_en_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] cpu_rdata_r;
    logic [31:0] dma_rdata_r;
    logic        cpu_ready_r;
    logic        dma_ready_r;
    logic        cpu_err_r;
    logic        dma_err_r;
    logic        busy_r;

    rr_arb2 u_rr_arb2 (
        .req      ({dma_req, cpu_req}),
        .last_gnt (last_gnt_r),
        .grant    (arb_gnt_s)
    );

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_r;

    // Count cycles spent in ACCESS; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_r == ACCESS) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= 8'd0;
        end
    end

    // A late mem_ack in the expiring cycle still completes normally.
    assign tmo_s = (state_r == ACCESS) && !mem_ack && (tmo_cnt_r == TMO_LIMIT);
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^(8'(TIMEOUT));
    assign tmo_s            = 1'b0;
`endif

    // The access ends on the cycle that leaves ACCESS.
    assign finish_s = (state_r == ACCESS) && (mem_ack || tmo_s);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (finish_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ACCESS;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch, response registers and grant history.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_r       <= GNT_CPU;
            last_gnt_r  <= GNT_DMA;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            cpu_rdata_r <= 32'd0;
            dma_rdata_r <= 32'd0;
            cpu_ready_r <= 1'b0;
            dma_ready_r <= 1'b0;
            cpu_err_r   <= 1'b0;
            dma_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_en_r <= (state_s == ACCESS);
            busy_r   <= (state_s != IDLE);

            if ((state_r == IDLE) && (cpu_req || dma_req)) begin
                gnt_r <= arb_gnt_s;
                if (arb_gnt_s == GNT_CPU) begin
                    mem_we_r    <= cpu_we;
                    mem_addr_r  <= cpu_addr;
                    mem_wdata_r <= cpu_wdata;
                end else begin
                    mem_we_r    <= dma_we;
                    mem_addr_r  <= dma_addr;
                    mem_wdata_r <= dma_wdata;
                end
            end else if (finish_s) begin
                mem_we_r <= 1'b0;
            end

            cpu_ready_r <= finish_s && (gnt_r == GNT_CPU);
            dma_ready_r <= finish_s && (gnt_r == GNT_DMA);
            cpu_err_r   <= finish_s && tmo_s && (gnt_r == GNT_CPU);
            dma_err_r   <= finish_s && tmo_s && (gnt_r == GNT_DMA);

            // Only reads update the granted port's rdata; writes leave it alone.
            if (finish_s && !mem_we_r) begin
                if (gnt_r == GNT_CPU) begin
                    cpu_rdata_r <= tmo_s ? ERR_DATA : mem_rdata;
                end else begin
                    dma_rdata_r <= tmo_s ? ERR_DATA : mem_rdata;
                end
            end

            if (state_r == DONE) begin
                last_gnt_r <= gnt_r;
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dma_rdata = dma_rdata_r;
    assign cpu_ready = cpu_ready_r;
    assign dma_ready = dma_ready_r;
    assign cpu_err   = cpu_err_r;
    assign dma_err   = dma_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single reads/writes, round-robin,
// reset mid-access, stray mem_ack and the optional access timeout.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [31:0] dma_addr = 32'd0;
    logic [31:0] dma_wdata = 32'd0;
    logic [31:0] dma_rdata;
    logic        dma_ready;
    logic        dma_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ready (dma_ready),
        .dma_err   (dma_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({mem_en, mem_we, busy, cpu_ready, dma_ready, cpu_err, dma_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b",
                     {mem_en, mem_we, busy, cpu_ready, dma_ready, cpu_err, dma_err}, 7'b0);
        end
        n_checks++;
        if ({cpu_rdata, dma_rdata} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected %h", {cpu_rdata, dma_rdata}, 64'd0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        tick();                                      // ACCESS cycle 1
        n_checks++;
        if ({mem_en, mem_we, busy, cpu_ready} !== 4'b1010 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL cpu_read_cmd: got en/we/busy/rdy=%b addr=%h expected 1010 addr=00000040",
                     {mem_en, mem_we, busy, cpu_ready}, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();                                      // DONE: third cycle
        n_checks++;
        if ({cpu_ready, dma_ready, cpu_err, mem_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL cpu_read_ready: got cpu_rdy/dma_rdy/err/en=%b expected 1000",
                     {cpu_ready, dma_ready, cpu_err, mem_en});
        end
        n_checks++;
        if (cpu_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL cpu_read_data: got %h expected 12345678", cpu_rdata);
        end
        cpu_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();                                      // IDLE
        n_checks++;
        if (cpu_ready !== 1'b0 || busy !== 1'b0 || cpu_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL cpu_read_after: got rdy=%b busy=%b rdata=%h expected 0 0 12345678",
                     cpu_ready, busy, cpu_rdata);
        end
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hCAFEF00D;
        mem_rdata = 32'h55555555;
        tick();                                      // ACCESS cycle 1
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h100 ||
                mem_wdata !== 32'hCAFEF00D || dma_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL dma_write_cmd[%0d]: got en/we=%b addr=%h wdata=%h rdy=%b expected 11 00000100 cafef00d 0",
                         i, {mem_en, mem_we}, mem_addr, mem_wdata, dma_ready);
            end
            if (i == 4) mem_ack = 1'b1;
            tick();
        end
        n_checks++;
        if ({dma_ready, cpu_ready, dma_err, mem_en} !== 4'b1000 || dma_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL dma_write_done: got rdy/cpu_rdy/err/en=%b rdata=%h expected 1000 00000000",
                     {dma_ready, cpu_ready, dma_err, mem_en}, dma_rdata);
        end
        dma_req = 1'b0; dma_we = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        n_checks++;
        if (dma_ready !== 1'b0 || busy !== 1'b0 || dma_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL dma_write_after: got rdy=%b busy=%b rdata=%h expected 0 0 00000000",
                     dma_ready, busy, dma_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_addr;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        for (int n = 0; n < 4; n++) begin
            exp_rdy  = (n % 2 == 0) ? 2'b10 : 2'b01;   // {cpu, dma}
            exp_addr = (n % 2 == 0) ? 32'h10 : 32'h20;
            tick();                                  // ACCESS
            n_checks++;
            if (mem_addr !== exp_addr || mem_en !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got addr=%h en=%b expected addr=%h en=1",
                         n, mem_addr, mem_en, exp_addr);
            end
            mem_ack = 1'b1; mem_rdata = 32'hA0000000 + 32'(n);
            tick();                                  // DONE
            n_checks++;
            if ({cpu_ready, dma_ready} !== exp_rdy) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", n, {cpu_ready, dma_ready}, exp_rdy);
            end
            n_checks++;
            if (((n % 2 == 0) ? cpu_rdata : dma_rdata) !== 32'hA0000000 + 32'(n)) begin
                n_fail++;
                $display("FAIL rr_rdata[%0d]: got cpu=%h dma=%h expected %h",
                         n, cpu_rdata, dma_rdata, 32'hA0000000 + 32'(n));
            end
            mem_ack = 1'b0;
            tick();                                  // IDLE
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_in_access();
        // Complete a CPU access first so the last grant is CPU before reset.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        cpu_req = 1'b0; mem_ack = 1'b0;
        tick();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
        tick();                                      // ACCESS cycle 1
        tick();                                      // ACCESS cycle 2
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL rst_access_pre: got en=%b addr=%h expected 1 00000200", mem_en, mem_addr);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({mem_en, busy, dma_ready, cpu_ready} !== 4'b0000 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_access_abort: got en/busy/dma_rdy/cpu_rdy=%b cpu_rdata=%h expected 0000 00000000",
                     {mem_en, busy, dma_ready, cpu_ready}, cpu_rdata);
        end
        reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h300;
        tick();                                      // both high: CPU must win
        n_checks++;
        if (mem_addr !== 32'h300 || dma_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_first_tie: got addr=%h dma_rdy=%b expected 00000300 0", mem_addr, dma_ready);
        end
        mem_ack = 1'b1; mem_rdata = 32'h99;
        tick();
        n_checks++;
        if ({cpu_ready, dma_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_first_ready: got %b expected 10", {cpu_ready, dma_ready});
        end
        cpu_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
        do_reset();
    endtask

    task automatic test_idle_ack();
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({mem_en, busy, cpu_ready, dma_ready, cpu_err, dma_err} !== 6'b0) begin
                n_fail++;
                $display("FAIL idle_ack[%0d]: got %b expected 000000", i,
                         {mem_en, busy, cpu_ready, dma_ready, cpu_err, dma_err});
            end
        end
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        mem_rdata = 32'h0BADF00D;
        tick();                                      // ACCESS cycle 1
`ifdef MEM_ARBITER_TIMEOUT_EN
        tick(); tick(); tick();                      // ACCESS cycles 2..4
        n_checks++;
        if (cpu_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: got rdy=%b busy=%b expected 0 1", cpu_ready, busy);
        end
        tick();                                      // DONE after 4 ACCESS cycles
        n_checks++;
        if ({cpu_ready, cpu_err, dma_ready} !== 3'b110 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL tmo_abort: got rdy/err/dma=%b rdata=%h expected 110 deadbeef",
                     {cpu_ready, cpu_err, dma_ready}, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        tick();
        // mem_ack arriving in the expiring cycle completes normally.
        cpu_req = 1'b1;
        tick();
        tick(); tick(); tick();
        mem_ack = 1'b1;
        tick();
        n_checks++;
        if ({cpu_ready, cpu_err} !== 2'b10 || cpu_rdata !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL tmo_ack_wins: got rdy/err=%b rdata=%h expected 10 0badf00d",
                     {cpu_ready, cpu_err}, cpu_rdata);
        end
        cpu_req = 1'b0; mem_ack = 1'b0;
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        n_checks++;
        if ({busy, mem_en, cpu_ready, cpu_err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL no_tmo_wait: got busy/en/rdy/err=%b expected 1100",
                     {busy, mem_en, cpu_ready, cpu_err});
        end
        cpu_req = 1'b0;
        do_reset();
`endif
    endtask

    // Watchdog against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_round_robin();
        test_reset_in_access();
        test_idle_ack();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
